rv32i_core: RTL and testbench



---
 rtl/rv32i_pkg.sv | 47 ++++
 rtl/rv32i_regfile.sv | 55 +++++
 rtl/rv32i_core.sv | 216 +++++++++++++++++++++
 tb/tb_rv32i_core.sv | 133 +++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared constants and types for the rv32i_core slice.
//   - Opcode constants for the supported RV32I major opcodes
//   - funct3 / funct7 constants
//   - ALU operation enum
//   - Sign-extension helper for 12-bit immediates
package rv32i_pkg;

    // Major opcodes (inst[6:0])
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // funct3 encodings
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL     = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_ADDI    = 3'b000;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;

    // funct7 encodings
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_SLL = 3'd2,
        ALU_SLT = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SRL = 3'd5,
        ALU_OR  = 3'd6,
        ALU_AND = 3'd7
    } alu_op_e;

    // Sign-extend a 12-bit immediate to 32 bits.
    function automatic logic [31:0] sext12(input logic [11:0] imm);
        return {{20{imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/rv32i_regfile.sv
// rv32i_regfile: 32 x XLEN integer register file.
//   clk_i      - system clock, write commits on rising edge
//   rst_ni     - asynchronous active-low clear of every register
//   we_i       - write enable
//   waddr_i    - write register index (index 0 is never written)
//   wdata_i    - write data
//   raddr1_i   - read port 1 index, rdata1_o combinational result
//   raddr2_i   - read port 2 index, rdata2_o combinational result
// Reads have no write bypass: a write is visible from the next cycle.
module rv32i_regfile
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            we_i,
    input  logic [4:0]      waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [4:0]      raddr1_i,
    output logic [XLEN-1:0] rdata1_o,
    input  logic [4:0]      raddr2_i,
    output logic [XLEN-1:0] rdata2_o
);

    logic [XLEN-1:0] regs [32];

    // Register storage: async clear, single synchronous write port, x0 never written.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= {XLEN{1'b0}};
            end
        end else if (we_i && (waddr_i != 5'd0)) begin
            regs[waddr_i] <= wdata_i;
        end
    end

    // Combinational read ports; x0 forced to zero regardless of storage.
    always_comb begin
        rdata1_o = {XLEN{1'b0}};
        rdata2_o = {XLEN{1'b0}};
        if (raddr1_i != 5'd0) begin
            rdata1_o = regs[raddr1_i];
        end else begin
            rdata1_o = {XLEN{1'b0}};
        end
        if (raddr2_i != 5'd0) begin
            rdata2_o = regs[raddr2_i];
        end else begin
            rdata2_o = {XLEN{1'b0}};
        end
    end

endmodule

// File: rtl/rv32i_core.sv
// rv32i_core: single-cycle RV32I integer subset core.
//   clk         - system clock, PC / register / DMEM updates on rising edge
//   reset       - asynchronous active-low reset (0 = clear state, 1 = run)
//   instruction - instruction word at address pc, executed this cycle
//   pc          - current program counter (registered)
// Supported: add sub sll slt xor srl or and, addi, lw, sw, beq, bne.
// Anything else executes as a NOP (pc + 4, no architectural writes).
// Data memory is internal, word addressed, combinational read.
module rv32i_core
    import rv32i_pkg::*;
#(
    parameter int          XLEN       = 32,
    parameter int          DMEM_WORDS = 64,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     instruction,
    output logic [XLEN-1:0] pc
);

    localparam int DMEM_AW = $clog2(DMEM_WORDS);

    // Instruction fields
    logic [6:0] opcode_s;
    logic [4:0] rd_s;
    logic [2:0] funct3_s;
    logic [4:0] rs1_s;
    logic [4:0] rs2_s;
    logic [6:0] funct7_s;

    assign opcode_s = instruction[6:0];
    assign rd_s     = instruction[11:7];
    assign funct3_s = instruction[14:12];
    assign rs1_s    = instruction[19:15];
    assign rs2_s    = instruction[24:20];
    assign funct7_s = instruction[31:25];

    // State
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] dmem [DMEM_WORDS];

    // Control
    logic            reg_we_s;
    logic            mem_we_s;
    logic            wb_mem_s;
    logic            use_imm_s;
    logic            is_beq_s;
    logic            is_bne_s;
    alu_op_e         alu_op_s;

    // Datapath
    logic [XLEN-1:0] rs1_data_s;
    logic [XLEN-1:0] rs2_data_s;
    logic [XLEN-1:0] imm_i_s;
    logic [XLEN-1:0] imm_s_s;
    logic [XLEN-1:0] imm_b_s;
    logic [XLEN-1:0] alu_b_s;
    logic [XLEN-1:0] alu_res_s;
    logic [XLEN-1:0] wb_data_s;
    logic [XLEN-1:0] mem_rdata_s;
    logic [DMEM_AW-1:0] dmem_idx_s;
    logic            branch_taken_s;

    assign pc = pc_q;

    rv32i_regfile #(
        .XLEN(XLEN)
    ) u_regfile (
        .clk_i    (clk),
        .rst_ni   (reset),
        .we_i     (reg_we_s),
        .waddr_i  (rd_s),
        .wdata_i  (wb_data_s),
        .raddr1_i (rs1_s),
        .rdata1_o (rs1_data_s),
        .raddr2_i (rs2_s),
        .rdata2_o (rs2_data_s)
    );

    // Immediate generation: I, S and B formats, all sign-extended.
    assign imm_i_s = sext12(instruction[31:20]);
    assign imm_s_s = sext12({instruction[31:25], instruction[11:7]});
    assign imm_b_s = {{19{instruction[31]}}, instruction[31], instruction[7],
                      instruction[30:25], instruction[11:8], 1'b0};

    // Control decode; unsupported encodings leave all write enables low.
    always_comb begin
        reg_we_s  = 1'b0;
        mem_we_s  = 1'b0;
        wb_mem_s  = 1'b0;
        use_imm_s = 1'b0;
        is_beq_s  = 1'b0;
        is_bne_s  = 1'b0;
        alu_op_s  = ALU_ADD;
        case (opcode_s)
            OP_R: begin
                reg_we_s = 1'b1;
                case (funct3_s)
                    F3_ADD_SUB: begin
                        if (funct7_s == F7_BASE) begin
                            alu_op_s = ALU_ADD;
                        end else if (funct7_s == F7_SUB) begin
                            alu_op_s = ALU_SUB;
                        end else begin
                            reg_we_s = 1'b0;
                        end
                    end
                    F3_SLL:  alu_op_s = ALU_SLL;
                    F3_SLT:  alu_op_s = ALU_SLT;
                    F3_XOR:  alu_op_s = ALU_XOR;
                    F3_SRL:  alu_op_s = ALU_SRL;
                    F3_OR:   alu_op_s = ALU_OR;
                    F3_AND:  alu_op_s = ALU_AND;
                    default: reg_we_s = 1'b0;
                endcase
                // Only add/sub accept a non-zero funct7 (sub); sra etc. are NOPs.
                if ((funct3_s != F3_ADD_SUB) && (funct7_s != F7_BASE)) begin
                    reg_we_s = 1'b0;
                end else begin
                    reg_we_s = reg_we_s;
                end
            end
            OP_IMM: begin
                use_imm_s = 1'b1;
                if (funct3_s == F3_ADDI) begin
                    reg_we_s = 1'b1;
                end else begin
                    reg_we_s = 1'b0;
                end
            end
            OP_LOAD: begin
                // funct3 ignored: every load is a word load.
                use_imm_s = 1'b1;
                reg_we_s  = 1'b1;
                wb_mem_s  = 1'b1;
            end
            OP_STORE: begin
                // funct3 ignored: every store is a word store.
                use_imm_s = 1'b1;
                mem_we_s  = 1'b1;
            end
            OP_BRANCH: begin
                case (funct3_s)
                    F3_BEQ:  is_beq_s = 1'b1;
                    F3_BNE:  is_bne_s = 1'b1;
                    default: is_beq_s = 1'b0;
                endcase
            end
            default: reg_we_s = 1'b0;
        endcase
    end

    // Store offset uses the S-format split immediate, everything else I-format.
    assign alu_b_s = use_imm_s ? ((opcode_s == OP_STORE) ? imm_s_s : imm_i_s) : rs2_data_s;

    // ALU: arithmetic wraps modulo 2^32, shift amount is the low five bits.
    always_comb begin
        alu_res_s = {XLEN{1'b0}};
        case (alu_op_s)
            ALU_ADD: alu_res_s = rs1_data_s + alu_b_s;
            ALU_SUB: alu_res_s = rs1_data_s - alu_b_s;
            ALU_SLL: alu_res_s = rs1_data_s << alu_b_s[4:0];
            ALU_SLT: alu_res_s = {{(XLEN-1){1'b0}}, ($signed(rs1_data_s) < $signed(alu_b_s))};
            ALU_XOR: alu_res_s = rs1_data_s ^ alu_b_s;
            ALU_SRL: alu_res_s = rs1_data_s >> alu_b_s[4:0];
            ALU_OR:  alu_res_s = rs1_data_s | alu_b_s;
            ALU_AND: alu_res_s = rs1_data_s & alu_b_s;
            default: alu_res_s = {XLEN{1'b0}};
        endcase
    end

    // Upper address bits and the byte offset are dropped, so addresses alias.
    assign dmem_idx_s  = alu_res_s[DMEM_AW+1:2];
    assign mem_rdata_s = dmem[dmem_idx_s];
    assign wb_data_s   = wb_mem_s ? mem_rdata_s : alu_res_s;

    // Branch resolution and next-PC selection.
    always_comb begin
        branch_taken_s = 1'b0;
        if (is_beq_s) begin
            branch_taken_s = (rs1_data_s == rs2_data_s);
        end else if (is_bne_s) begin
            branch_taken_s = (rs1_data_s != rs2_data_s);
        end else begin
            branch_taken_s = 1'b0;
        end
        if (branch_taken_s) begin
            pc_d = pc_q + imm_b_s;
        end else begin
            pc_d = pc_q + 32'd4;
        end
    end

    // Program counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Data memory: async clear, word write on store.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DMEM_WORDS; i++) begin
                dmem[i] <= {XLEN{1'b0}};
            end
        end else if (mem_we_s) begin
            dmem[dmem_idx_s] <= rs2_data_s;
        end
    end

endmodule

// File: tb/tb_rv32i_core.sv
// tb_rv32i_core: directed self-checking bench for rv32i_core.
module tb_rv32i_core;
    import rv32i_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic [31:0] instruction;
    logic [31:0] pc;

    int checks;
    int failures;

    logic [31:0] exp_regs [32];
    logic [31:0] exp_dmem [64];
    logic [31:0] exp_pc;

    rv32i_core u_dut (
        .clk         (clk),
        .reset       (reset),
        .instruction (instruction),
        .pc          (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%08h expected=%08h", tag, actual, expected);
        end
    endtask

    // Apply one instruction for one clock; returns #1 after the edge.
    task automatic exec(input logic [31:0] instr);
        instruction = instr;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_state(input string tag);
        for (int i = 0; i < 32; i++) begin
            check_eq($sformatf("%s_x%0d", tag, i), u_dut.u_regfile.regs[i], exp_regs[i]);
        end
        for (int i = 0; i < 64; i++) begin
            check_eq($sformatf("%s_dmem%0d", tag, i), u_dut.dmem[i], exp_dmem[i]);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 32; i++) exp_regs[i] = 32'd0;
        for (int i = 0; i < 64; i++) exp_dmem[i] = 32'd0;
        reset       = 1'b0;
        instruction = NOP;

        // 1. Reset held across edges, then release and sequence NOPs.
        repeat (3) @(posedge clk);
        #1;
        check_eq("pc_in_reset", pc, 32'h0);
        check_all_state("reset");
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("pc_after_release", pc, 32'h0);
        exec(NOP); check_eq("pc_nop1", pc, 32'd4);
        exec(NOP); check_eq("pc_nop2", pc, 32'd8);
        exec(NOP); check_eq("pc_nop3", pc, 32'd12);

        // 2. addi / add / sub.
        exec(32'h0050_0093); check_eq("addi_x1", u_dut.u_regfile.regs[1], 32'd5);
        exec(32'hFFD0_0113); check_eq("addi_x2", u_dut.u_regfile.regs[2], 32'hFFFF_FFFD);
        exec(32'h0020_81B3); check_eq("add_x3", u_dut.u_regfile.regs[3], 32'd2);
        exec(32'h4020_8233); check_eq("sub_x4", u_dut.u_regfile.regs[4], 32'd8);
        check_eq("pc_after_alu", pc, 32'd28);

        // 3. Store / load round trip.
        exec(32'h0020_2423); check_eq("sw_dmem2", u_dut.dmem[2], 32'hFFFF_FFFD);
        exec(32'h0080_2283); check_eq("lw_x5", u_dut.u_regfile.regs[5], 32'hFFFF_FFFD);
        check_eq("pc_after_mem", pc, 32'd36);

        // 4. Branches.
        exec(32'h0010_8863); check_eq("beq_taken", pc, 32'd52);
        exec(32'h0020_8863); check_eq("beq_not_taken", pc, 32'd56);
        exec(32'hFE20_9CE3); check_eq("bne_back", pc, 32'd48);

        // 5. x0 rules and unsupported opcode.
        exec(32'h0070_0013); check_eq("x0_zero", u_dut.u_regfile.regs[0], 32'd0);
        exec(32'h0010_0333); check_eq("add_x6_x0", u_dut.u_regfile.regs[6], 32'd5);
        check_eq("pc_after_x0", pc, 32'd56);
        exp_regs[1] = 32'd5;        exp_regs[2] = 32'hFFFF_FFFD;
        exp_regs[3] = 32'd2;        exp_regs[4] = 32'd8;
        exp_regs[5] = 32'hFFFF_FFFD; exp_regs[6] = 32'd5;
        exp_dmem[2] = 32'hFFFF_FFFD;
        exec(32'hFFFF_FFFF); check_eq("pc_illegal", pc, 32'd60);
        check_all_state("illegal");

        // Remaining R-type ops and address wrap onto the array.
        exec(32'h0011_2433); check_eq("slt_x8", u_dut.u_regfile.regs[8], 32'd1);
        exec(32'h0011_54B3); check_eq("srl_x9", u_dut.u_regfile.regs[9], 32'h07FF_FFFF);
        exec(32'h0010_9533); check_eq("sll_x10", u_dut.u_regfile.regs[10], 32'h0000_00A0);
        exec(32'h0020_C5B3); check_eq("xor_x11", u_dut.u_regfile.regs[11], 32'hFFFF_FFF8);
        exec(32'h0020_E633); check_eq("or_x12", u_dut.u_regfile.regs[12], 32'hFFFF_FFFD);
        exec(32'h0020_F6B3); check_eq("and_x13", u_dut.u_regfile.regs[13], 32'd5);
        exec(32'h1010_2423); check_eq("sw_wrap_dmem2", u_dut.dmem[2], 32'd5);
        check_eq("pc_after_wrap", pc, 32'd88);

        // 6. Async reset between edges during a store.
        for (int i = 0; i < 32; i++) exp_regs[i] = 32'd0;
        for (int i = 0; i < 64; i++) exp_dmem[i] = 32'd0;
        instruction = 32'h0020_2623;
        #2;
        reset = 1'b0;
        #1;
        check_eq("pc_async_reset", pc, 32'h0);
        check_all_state("async");
        @(posedge clk);
        #1;
        check_eq("no_store_dmem3", u_dut.dmem[3], 32'd0);
        check_eq("pc_held", pc, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        exec(NOP); check_eq("pc_restart", pc, 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
